axis_out_serializer: RTL and testbench



---
 rtl/axis_pkg.sv | 23 ++
 rtl/axis_out_serializer.sv | 134 +++++++++++++
 tb/tb_axis_out_serializer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream width-conversion blocks.
//   ser_state_t    : serializer FSM state (EMPTY = hold register free,
//                    SERIAL = hold register occupied, segments going out)
//   ratio_legal()  : true when a wide width splits into whole narrow,
//                    byte-aligned beats
//   keep_width()   : TKEEP width for a given TDATA width (one bit per byte)
package axis_pkg;

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_SERIAL = 1'b1
    } ser_state_t;

    function automatic bit ratio_legal(input int in_width, input int out_width);
        return (out_width > 0) && (out_width % 8 == 0) &&
               (in_width >= out_width) && (in_width % out_width == 0);
    endfunction

    function automatic int keep_width(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/axis_out_serializer.sv
// Wide-to-narrow AXI-Stream serializer placed between the systolic-array
// result stream and the DMA S2MM port. Each accepted wide beat is held and
// sent out as `ratio` narrow beats, least-significant segment first.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   S_AXIS_*        : wide slave stream (TDATA inWidth, TKEEP inWidth/8)
//   M_AXIS_*        : narrow master stream (TDATA outWidth, TKEEP outWidth/8)
//
// Handshake: a beat moves on a rising edge where TVALID and TREADY are both
// high; once M_AXIS_TVALID is high, data/keep/last stay stable until taken.
// S_AXIS_TREADY passes M_AXIS_TREADY through on the last segment so a new
// wide beat can load in the same cycle the old one drains (no bubble).
//
// `state` is the FSM state register, kept as a named signal for probing.
module axis_out_serializer
    import axis_pkg::*;
#(
    parameter int arraySize  = 2,
    parameter int outputBits = 32,
    parameter int inWidth    = arraySize * outputBits * 4,
    parameter int outWidth   = 64,
    parameter int ratio      = inWidth / outWidth,
    parameter int segWidth   = (ratio > 1) ? $clog2(ratio) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [inWidth-1:0]             S_AXIS_TDATA,
    input  logic [keep_width(inWidth)-1:0] S_AXIS_TKEEP,
    input  logic                           S_AXIS_TLAST,
    input  logic                           S_AXIS_TVALID,
    output logic                           S_AXIS_TREADY,
    output logic [outWidth-1:0]            M_AXIS_TDATA,
    output logic [keep_width(outWidth)-1:0] M_AXIS_TKEEP,
    output logic                           M_AXIS_TLAST,
    output logic                           M_AXIS_TVALID,
    input  logic                           M_AXIS_TREADY
);

    localparam int InKeep  = keep_width(inWidth);
    localparam int OutKeep = keep_width(outWidth);

    generate
        if (!ratio_legal(inWidth, outWidth)) begin : g_bad_ratio
            $error("axis_out_serializer: inWidth must be a multiple of outWidth");
        end
    endgenerate

    ser_state_t          state, state_d;
    logic [inWidth-1:0]  hold_data;
    logic [InKeep-1:0]   hold_keep;
    logic                hold_last;
    logic [segWidth-1:0] seg, seg_d;
    logic                load;

    logic full;
    logic last_seg;
    logic s_acc;
    logic m_acc;

    assign full     = (state == ST_SERIAL);
    assign last_seg = (seg == segWidth'(ratio - 1));

    assign S_AXIS_TREADY = !rst && (!full || (M_AXIS_TREADY && last_seg));
    assign s_acc         = S_AXIS_TVALID && S_AXIS_TREADY;
    assign m_acc         = M_AXIS_TVALID && M_AXIS_TREADY;

    // Outputs are forced quiet while rst is high so an in-flight beat is
    // never offered during the reset cycle itself.
    always_comb begin
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TDATA  = '0;
        M_AXIS_TKEEP  = '0;
        M_AXIS_TLAST  = 1'b0;
        if (!rst) begin
            M_AXIS_TVALID = full;
            M_AXIS_TDATA  = hold_data[int'(seg) * outWidth +: outWidth];
            M_AXIS_TKEEP  = hold_keep[int'(seg) * OutKeep +: OutKeep];
            M_AXIS_TLAST  = full && hold_last && last_seg;
        end
    end

    always_comb begin
        state_d = state;
        seg_d   = seg;
        load    = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (s_acc) begin
                    load    = 1'b1;
                    seg_d   = '0;
                    state_d = ST_SERIAL;
                end
            end
            ST_SERIAL: begin
                if (m_acc) begin
                    if (!last_seg) begin
                        seg_d = seg + 1'b1;
                    end else if (s_acc) begin
                        // Drain and refill in the same cycle.
                        load  = 1'b1;
                        seg_d = '0;
                    end else begin
                        seg_d   = '0;
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
                seg_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            seg       <= '0;
            hold_data <= '0;
            hold_keep <= '0;
            hold_last <= 1'b0;
        end else begin
            state <= state_d;
            seg   <= seg_d;
            if (load) begin
                hold_data <= S_AXIS_TDATA;
                hold_keep <= S_AXIS_TKEEP;
                hold_last <= S_AXIS_TLAST;
            end
        end
    end

endmodule

// File: tb/tb_axis_out_serializer.sv
// Bench for axis_out_serializer at default parameters (256 -> 64, ratio 4).
// The reference model is a queue of expected narrow beats: every accepted
// wide beat pushes its four segments; the narrow side pops on each transfer.
// Ready/valid expectations follow from how many narrow beats are pending.
module tb_axis_out_serializer;

    localparam int IW = 256;
    localparam int OW = 64;
    localparam int R  = IW / OW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [IW-1:0]  S_AXIS_TDATA  = '0;
    logic [IW/8-1:0] S_AXIS_TKEEP = '0;
    logic           S_AXIS_TLAST  = 1'b0;
    logic           S_AXIS_TVALID = 1'b0;
    logic           S_AXIS_TREADY;
    logic [OW-1:0]  M_AXIS_TDATA;
    logic [OW/8-1:0] M_AXIS_TKEEP;
    logic           M_AXIS_TLAST;
    logic           M_AXIS_TVALID;
    logic           M_AXIS_TREADY = 1'b1;

    axis_out_serializer dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TKEEP  (S_AXIS_TKEEP),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TKEEP  (M_AXIS_TKEEP),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait budget expired", name);
    endtask

    // ---------------- downstream ready driver ----------------
    int       rdy_mode = 0;        // 0 always ready, 1 random, 2 fixed pattern
    int       pidx     = 0;
    logic [6:0] pat    = 7'b1101001; // bit0 first: 1,0,0,1,0,1,1

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: M_AXIS_TREADY = 1'($urandom_range(0, 1));
            2: begin
                M_AXIS_TREADY = pat[pidx % 7];
                pidx++;
            end
            default: M_AXIS_TREADY = 1'b1;
        endcase
    end

    // ---------------- scoreboard ----------------
    logic [72:0] exp_q[$];   // {last, keep[7:0], data[63:0]}
    logic [72:0] log_q[$];   // narrow beats actually transferred
    int          log_cyc[$];

    always @(negedge clk) begin
        int pending;
        if (rst) begin
            chk("rst_m_tvalid", M_AXIS_TVALID, 1'b0);
            chk("rst_s_tready", S_AXIS_TREADY, 1'b0);
            chk("rst_m_tdata", M_AXIS_TDATA, '0);
            exp_q.delete();
        end else begin
            pending = exp_q.size();
            chk("s_tready", S_AXIS_TREADY,
                (pending == 0) || (pending == 1 && M_AXIS_TREADY));
            chk("m_tvalid", M_AXIS_TVALID, pending > 0);
            if (pending > 0 && M_AXIS_TVALID) begin
                chk("m_beat", {M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA}, exp_q[0]);
                if (M_AXIS_TREADY) begin
                    void'(exp_q.pop_front());
                    log_q.push_back({M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA});
                    log_cyc.push_back(cyc);
                end
            end
            if (S_AXIS_TVALID && S_AXIS_TREADY) begin
                for (int k = 0; k < R; k++)
                    exp_q.push_back({S_AXIS_TLAST && (k == R - 1),
                                     S_AXIS_TKEEP[k*8 +: 8],
                                     S_AXIS_TDATA[k*OW +: OW]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [IW-1:0] d, input logic [IW/8-1:0] k,
                        input logic l, output int acc_cyc);
        int  n;
        bit  done;
        S_AXIS_TDATA  = d;
        S_AXIS_TKEEP  = k;
        S_AXIS_TLAST  = l;
        S_AXIS_TVALID = 1'b1;
        n = 0;
        done = 0;
        acc_cyc = -1;
        while (!done) begin
            @(negedge clk);
            if (S_AXIS_TREADY) begin
                done = 1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 300) begin
                timeout_fail("s_accept");
                done = 1;
            end
        end
    endtask

    task automatic idle_s();
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) timeout_fail("drain");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_q.delete();
        log_cyc.delete();
    endtask

    function automatic logic [IW-1:0] seg_pattern(input logic [55:0] hi);
        logic [IW-1:0] d;
        for (int k = 0; k < R; k++) d[k*OW +: OW] = {hi, 8'(k)};
        return d;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int        acc;
        int        n;
        logic [7:0] lasts;
        logic [IW-1:0] rd;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tvalid", M_AXIS_TVALID, 1'b0);
        chk("post_rst_tdata", M_AXIS_TDATA, '0);
        chk("post_rst_tkeep", M_AXIS_TKEEP, '0);
        chk("post_rst_tlast", M_AXIS_TLAST, 1'b0);
        chk("post_rst_tready", S_AXIS_TREADY, 1'b1);
        @(posedge clk);
        #1;

        // Single wide beat, segment k = 64'h000k.
        clear_log();
        send(seg_pattern(56'h0), '1, 1'b1, acc);
        idle_s();
        drain();
        chk("single_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("single_data", log_q[k][63:0], 64'(k));
                chk("single_last", log_q[k][72], k == 3);
            end
            chk("single_latency", log_cyc[0] - acc, 1);
            chk("single_contig", log_cyc[3] - log_cyc[0], 3);
        end

        // Back-to-back: three wide beats, TLAST on the third.
        clear_log();
        send(seg_pattern(56'h10), '1, 1'b0, acc);
        send(seg_pattern(56'h20), '1, 1'b0, acc);
        send(seg_pattern(56'h30), '1, 1'b1, acc);
        idle_s();
        drain();
        chk("b2b_count", log_q.size(), 12);
        if (log_q.size() == 12) begin
            chk("b2b_contig", log_cyc[11] - log_cyc[0], 11);
            n = 0;
            for (int i = 0; i < 12; i++) if (log_q[i][72]) n++;
            chk("b2b_last_count", n, 1);
            chk("b2b_last_pos", log_q[11][72], 1'b1);
            chk("b2b_first", log_q[0][63:0], 64'h0000_0000_0000_1000);
            chk("b2b_final", log_q[11][63:0], 64'h0000_0000_0000_3003);
        end

        // Backpressure pattern.
        clear_log();
        pidx = 0;
        rdy_mode = 2;
        send(seg_pattern(56'h0), '1, 1'b1, acc);
        idle_s();
        drain();
        rdy_mode = 0;
        chk("bp_count", log_q.size(), 4);
        if (log_q.size() == 4)
            for (int k = 0; k < 4; k++) chk("bp_order", log_q[k][63:0], 64'(k));

        // Keep pass-through, including an all-zero segment.
        clear_log();
        send(seg_pattern(56'h4B), 32'h00FF_F0FF, 1'b1, acc);
        idle_s();
        drain();
        chk("keep_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            chk("keep0", log_q[0][71:64], 8'hFF);
            chk("keep1", log_q[1][71:64], 8'hF0);
            chk("keep2", log_q[2][71:64], 8'hFF);
            chk("keep3", log_q[3][71:64], 8'h00);
        end

        // Reset after two of four segments.
        clear_log();
        send(seg_pattern(56'h55_5555_5555_5555), '1, 1'b1, acc);
        idle_s();
        n = 0;
        while (log_q.size() < 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (log_q.size() < 2) timeout_fail("rst_wait");
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("after_rst_tvalid", M_AXIS_TVALID, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_discard_count", log_q.size(), 2);
        clear_log();
        send(seg_pattern(56'hAA_AAAA_AAAA_AAAA), '1, 1'b1, acc);
        idle_s();
        drain();
        chk("rst_next_count", log_q.size(), 4);
        if (log_q.size() == 4) chk("rst_next_seg0", log_q[0][63:0], 64'hAAAA_AAAA_AAAA_AA00);

        // TLAST=0 beat followed by TLAST=1 beat.
        clear_log();
        send(seg_pattern(56'h60), '1, 1'b0, acc);
        send(seg_pattern(56'h70), '1, 1'b1, acc);
        idle_s();
        drain();
        chk("tlast_count", log_q.size(), 8);
        if (log_q.size() == 8) begin
            for (int i = 0; i < 8; i++) lasts[i] = log_q[i][72];
            chk("tlast_pos", lasts, 8'b1000_0000);
        end

        // Randomized traffic with random downstream stalls and source gaps.
        rdy_mode = 1;
        for (int b = 0; b < 60; b++) begin
            for (int w = 0; w < 8; w++) rd[w*32 +: 32] = $urandom;
            send(rd, 32'($urandom), 1'($urandom_range(0, 1)), acc);
            if ($urandom_range(0, 3) == 0) begin
                idle_s();
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1;
            end
        end
        idle_s();
        drain();
        rdy_mode = 0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
